fc_result_reader: RTL and testbench
===================================

// Module: fc_result_reader
// PURPOSE
//  Reader at the far end of the FC output path: after the FC layer writes its final-layer
//  scores into SRAM e0, this block fetches them, streams each signed score out over a
//  valid/ready port and computes the argmax (predicted LeNet class). It is started by the
//  FC done pulse and owns the SRAM e0 read address while busy.
// PARAMETERS
//  DATA_WIDTH              8   bits per score (signed two's complement)
//  DATA_NUM_PER_SRAM_ADDR  4   scores packed per SRAM word
//  CLASS_NUM               10  number of final-layer scores
//  RESULT_BASE_ADDR        0   10-bit SRAM e0 word address of score 0
// PORTS
//  clk             in   1     clock
//  srstn           in   1     asynchronous active-low reset
//  start           in   1     one-cycle start pulse (fc_done)
//  sram_raddr_e0   out  10    SRAM e0 read address
//  sram_rdata_e0   in   32    SRAM e0 read data (DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH)
//  score_valid     out  1     score_data/score_idx valid
//  score_ready     in   1     downstream accepts score this cycle
//  score_data      out  8     signed score
//  score_idx       out  4     class index of score_data, $clog2(CLASS_NUM) bits
//  score_last      out  1     high with score_idx==CLASS_NUM-1
//  class_valid     out  1     class_id/class_score valid
//  class_id        out  4     argmax index
//  class_score     out  8     max score
//  busy            out  1     high from cycle after accepted start until done
//  done            out  1     one-cycle pulse when last score accepted and argmax final
// BEHAVIOUR
//  - Reset (async, srstn=0): all outputs 0; sram_raddr_e0=RESULT_BASE_ADDR; FSM IDLE.
//    Reset mid-operation aborts immediately; no partial result kept.
//  - Layout: score k at word RESULT_BASE_ADDR+k/4, lane k%4; lane 0 = bits [31:24],
//    lane 3 = bits [7:0]. Words fetched = ceil(CLASS_NUM/4) (3 by default).
//  - SRAM read latency 1 cycle: address driven in cycle t, rdata sampled at edge ending t+1.
//  - FSM: IDLE -start-> FETCH (drive word addr) -> LATCH (capture rdata into word buffer)
//    -> STREAM (present lanes in order) -> FETCH for next word, or DONE after last score
//    -> IDLE. Final word streams only CLASS_NUM%4 lanes when nonzero (2 by default).
//  - start ignored unless IDLE; start in same cycle as done has no effect.
//  - Stream handshake: transfer when score_valid&&score_ready; score_valid, data, idx and
//    last held stable until transfer; score_valid never drops without a transfer.
//    score_valid low in FETCH/LATCH (2 bubble cycles per word).
//  - Argmax: signed compare; on each transfer, update when score > current max (strict),
//    so ties keep the lower index; score 0 initialises max unconditionally.
//  - DONE state lasts 1 cycle: done=1, class_valid set and held with class_id/class_score
//    until next accepted start, which clears class_valid in the following cycle.
//  - busy=1 in FETCH/LATCH/STREAM/DONE; sram_raddr_e0 returns to RESULT_BASE_ADDR in IDLE.
//  - Min latency start->done with score_ready tied 1: 1+3*2+10 = 17 cycles default.
// TESTING
//  1. Scores 0..9 = {3,-5,7,1,0,2,-128,127,9,4}, ready=1 -> stream in order idx 0..9,
//     score_last on idx 9, class_id=7, class_score=127, done 17 cycles after start.
//  2. All scores -1 -> class_id=0, class_score=-1 (tie keeps lowest index).
//  3. score_ready toggled randomly incl. low 5 cycles on idx 4 -> no drop/dup, data stable
//     while stalled, same class result as ready=1.
//  4. Second start pulse while busy -> ignored; raddr sequence BASE,BASE+1,BASE+2 only once.
//  5. srstn asserted during STREAM of idx 5 -> all outputs 0 immediately; new start
//     reruns from idx 0 with correct result.
//  6. RESULT_BASE_ADDR=1000, scores {-3,-2,...} max at idx 9 -> reads 1000..1002, lanes 0-1
//     of word 1002 only, class_id=9.

Source files
------------

// File: rtl/fc_result_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fc_result_reader
//  Purpose  : Fetches final-layer FC scores from SRAM e0, streams them out over
//             valid/ready and reports the argmax (predicted class).
//  Revision : 1.0  initial release
// ============================================================================
module fc_result_reader #(
   parameter int DATA_WIDTH             = 8,
   parameter int DATA_NUM_PER_SRAM_ADDR = 4,
   parameter int CLASS_NUM              = 10,
   parameter int RESULT_BASE_ADDR       = 0
) (
   input  logic                                           clk,
   input  logic                                           srstn,
   input  logic                                           start,
   output logic [9:0]                                     sram_raddr_e0,
   input  logic [DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH-1:0]   sram_rdata_e0,
   output logic                                           score_valid,
   input  logic                                           score_ready,
   output logic [DATA_WIDTH-1:0]                          score_data,
   output logic [$clog2(CLASS_NUM)-1:0]                   score_idx,
   output logic                                           score_last,
   output logic                                           class_valid,
   output logic [$clog2(CLASS_NUM)-1:0]                   class_id,
   output logic [DATA_WIDTH-1:0]                          class_score,
   output logic                                           busy,
   output logic                                           done
);

   localparam int                     c_WORD_W    = DATA_NUM_PER_SRAM_ADDR * DATA_WIDTH;
   localparam int                     c_IDX_W     = $clog2(CLASS_NUM);
   localparam int                     c_LANE_W    = (DATA_NUM_PER_SRAM_ADDR > 1) ?
                                                    $clog2(DATA_NUM_PER_SRAM_ADDR) : 1;
   localparam logic [c_IDX_W-1:0]     c_LAST_IDX  = c_IDX_W'(CLASS_NUM - 1);
   localparam logic [c_LANE_W-1:0]    c_LAST_LANE = c_LANE_W'(DATA_NUM_PER_SRAM_ADDR - 1);
   localparam logic [9:0]             c_BASE      = 10'(RESULT_BASE_ADDR);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_FETCH  = 3'd1;
   localparam logic [2:0] c_LATCH  = 3'd2;
   localparam logic [2:0] c_STREAM = 3'd3;
   localparam logic [2:0] c_DONE   = 3'd4;

   logic [2:0]                   state_q, state_d;
   logic [9:0]                   word_q;
   logic [c_LANE_W-1:0]          lane_q;
   logic [c_IDX_W-1:0]           idx_q;
   logic [c_WORD_W-1:0]          buf_q;
   logic signed [DATA_WIDTH-1:0] max_q;
   logic [c_IDX_W-1:0]           max_idx_q;
   logic                         class_valid_q;
   logic [c_IDX_W-1:0]           class_id_q;
   logic [DATA_WIDTH-1:0]        class_score_q;

   logic [DATA_WIDTH-1:0]        w_lanes [DATA_NUM_PER_SRAM_ADDR];
   logic signed [DATA_WIDTH-1:0] w_score;
   logic                         w_xfer;
   logic                         w_last_score;
   logic                         w_new_max;
   logic signed [DATA_WIDTH-1:0] w_max_d;
   logic [c_IDX_W-1:0]           w_max_idx_d;

   // Lane 0 occupies the most significant bits of the SRAM word.
   for (genvar l = 0; l < DATA_NUM_PER_SRAM_ADDR; l++) begin : g_lane
      assign w_lanes[l] = buf_q[(DATA_NUM_PER_SRAM_ADDR-l)*DATA_WIDTH-1 -: DATA_WIDTH];
   end

   assign w_score      = w_lanes[lane_q];
   assign w_xfer       = (state_q == c_STREAM) && score_ready;
   assign w_last_score = (idx_q == c_LAST_IDX);
   assign w_new_max    = (idx_q == '0) || (w_score > max_q);
   assign w_max_d      = w_new_max ? w_score : max_q;
   assign w_max_idx_d  = w_new_max ? idx_q : max_idx_q;

   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         state_q <= c_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_IDLE:   if (start) state_d = c_FETCH;
         c_FETCH:  state_d = c_LATCH;
         c_LATCH:  state_d = c_STREAM;
         c_STREAM: begin
            if (w_xfer) begin
               if (w_last_score)              state_d = c_DONE;
               else if (lane_q == c_LAST_LANE) state_d = c_FETCH;
            end
         end
         c_DONE:   state_d = c_IDLE;
         default:  state_d = c_IDLE;
      endcase
   end

   always_comb begin
      score_valid   = (state_q == c_STREAM);
      busy          = (state_q != c_IDLE);
      done          = (state_q == c_DONE);
      score_data    = score_valid ? w_score : '0;
      score_idx     = score_valid ? idx_q : '0;
      score_last    = score_valid && w_last_score;
      sram_raddr_e0 = c_BASE + word_q;
      class_valid   = class_valid_q;
      class_id      = class_id_q;
      class_score   = class_score_q;
   end

   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         word_q        <= '0;
         lane_q        <= '0;
         idx_q         <= '0;
         buf_q         <= '0;
         max_q         <= '0;
         max_idx_q     <= '0;
         class_valid_q <= 1'b0;
         class_id_q    <= '0;
         class_score_q <= '0;
      end else begin
         if ((state_q == c_IDLE) && start) begin
            word_q        <= '0;
            lane_q        <= '0;
            idx_q         <= '0;
            class_valid_q <= 1'b0;
            class_id_q    <= '0;
            class_score_q <= '0;
         end
         if (state_q == c_LATCH) begin
            buf_q <= sram_rdata_e0;
         end
         if (w_xfer) begin
            max_q     <= w_max_d;
            max_idx_q <= w_max_idx_d;
            idx_q     <= idx_q + c_IDX_W'(1);
            // The result registers take the post-update max so they are final in DONE.
            if (w_last_score) begin
               class_valid_q <= 1'b1;
               class_id_q    <= w_max_idx_d;
               class_score_q <= w_max_d;
            end else if (lane_q == c_LAST_LANE) begin
               lane_q <= '0;
               word_q <= word_q + 10'd1;
            end else begin
               lane_q <= lane_q + c_LANE_W'(1);
            end
         end
         if (state_q == c_DONE) begin
            word_q <= '0;
            lane_q <= '0;
            idx_q  <= '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fc_result_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fc_result_reader
//  Purpose  : Randomized self-checking bench for fc_result_reader.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fc_result_reader;

   localparam int BASE = 1000;

   logic        clk = 1'b0;
   logic        srstn = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  sram_raddr_e0;
   logic [31:0] sram_rdata_e0;
   logic        score_valid;
   logic        score_ready = 1'b1;
   logic [7:0]  score_data;
   logic [3:0]  score_idx;
   logic        score_last;
   logic        class_valid;
   logic [3:0]  class_id;
   logic [7:0]  class_score;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   fc_result_reader #(
      .DATA_WIDTH             (8),
      .DATA_NUM_PER_SRAM_ADDR (4),
      .CLASS_NUM              (10),
      .RESULT_BASE_ADDR       (BASE)
   ) dut (
      .clk           (clk),
      .srstn         (srstn),
      .start         (start),
      .sram_raddr_e0 (sram_raddr_e0),
      .sram_rdata_e0 (sram_rdata_e0),
      .score_valid   (score_valid),
      .score_ready   (score_ready),
      .score_data    (score_data),
      .score_idx     (score_idx),
      .score_last    (score_last),
      .class_valid   (class_valid),
      .class_id      (class_id),
      .class_score   (class_score),
      .busy          (busy),
      .done          (done)
   );

   // Synchronous-read SRAM with one cycle of latency.
   logic [31:0] mem [1024];
   always @(posedge clk) sram_rdata_e0 <= mem[sram_raddr_e0];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   int         cur [10];
   int         exp_scores [10];
   int         exp_pos = 0;
   int         cyc = 0;
   int         start_cyc = 0;
   int         done_cnt = 0;
   int         rdy_mode = 0;
   bit         stall4_done = 1'b0;
   logic [9:0] alog [8];
   int         alog_n = 0;
   int         prev_valid = 0, prev_ready = 0, prev_data = 0, prev_idx = 0, prev_last = 0;

   // Ready driver: always-ready, or random with one forced 5-cycle stall on idx 4.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0) begin
            score_ready = 1'b1;
         end else if (score_valid && score_idx == 4'd4 && !stall4_done) begin
            stall4_done = 1'b1;
            score_ready = 1'b0;
            repeat (5) begin
               @(posedge clk);
               #1;
            end
            score_ready = 1'b1;
         end else begin
            score_ready = 1'($urandom_range(0, 1));
         end
      end
   end

   // Stream monitor: ordering, stability under stall, latency.
   always @(negedge clk) begin
      cyc++;
      if (!srstn) begin
         prev_valid = 0;
      end else begin
         if (start && !busy) start_cyc = cyc;
         if (busy && (alog_n == 0 || sram_raddr_e0 != alog[(alog_n-1) % 8])) begin
            if (alog_n < 8) alog[alog_n] = sram_raddr_e0;
            alog_n++;
         end
         if (prev_valid != 0 && prev_ready == 0) begin
            chk_eq("hold_valid", int'(score_valid), 1);
            chk_eq("hold_data", int'($signed(score_data)), prev_data);
            chk_eq("hold_idx", int'(score_idx), prev_idx);
            chk_eq("hold_last", int'(score_last), prev_last);
         end
         if (score_valid && score_ready) begin
            if (exp_pos < 10) begin
               chk_eq("stream_data", int'($signed(score_data)), exp_scores[exp_pos]);
               chk_eq("stream_idx", int'(score_idx), exp_pos);
               chk_eq("stream_last", int'(score_last), (exp_pos == 9) ? 1 : 0);
            end else begin
               chk_eq("extra_transfer", exp_pos, 9);
            end
            exp_pos++;
         end
         if (done) begin
            chk_eq("scores_before_done", exp_pos, 10);
            if (rdy_mode == 0) chk_eq("start_to_done", cyc - start_cyc, 17);
            done_cnt++;
         end
         prev_valid = int'(score_valid);
         prev_ready = int'(score_ready);
         prev_data  = int'($signed(score_data));
         prev_idx   = int'(score_idx);
         prev_last  = int'(score_last);
      end
   end

   task automatic load_scores();
      logic [31:0] word;
      for (int w = 0; w < 3; w++) begin
         word = $urandom;
         for (int l = 0; l < 4; l++) begin
            if (w * 4 + l < 10) word[31-8*l -: 8] = 8'(cur[w*4+l]);
         end
         mem[BASE+w] = word;
      end
      for (int k = 0; k < 10; k++) exp_scores[k] = cur[k];
   endtask

   task automatic model_argmax(output int id, output int mx);
      mx = cur[0];
      id = 0;
      for (int k = 1; k < 10; k++) begin
         if (cur[k] > mx) begin
            mx = cur[k];
            id = k;
         end
      end
   endtask

   task automatic random_scores();
      logic signed [7:0] b;
      for (int k = 0; k < 10; k++) begin
         b = 8'($urandom);
         cur[k] = int'(b);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic run_scores(input int mode, input bit mid_start, input bit start_at_done);
      int id, mx, d0;
      bit got;
      load_scores();
      model_argmax(id, mx);
      exp_pos     = 0;
      alog_n      = 0;
      stall4_done = 1'b0;
      rdy_mode    = mode;
      d0          = done_cnt;
      pulse_start();
      @(negedge clk);
      chk_eq("busy_after_start", int'(busy), 1);
      chk_eq("class_valid_cleared", int'(class_valid), 0);
      got = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
         if (mid_start && c == 6) begin
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
         end
         @(negedge clk);
         if (done) got = 1'b1;
      end
      chk_eq("done_seen", int'(got), 1);
      if (got) begin
         chk_eq("class_valid_at_done", int'(class_valid), 1);
         chk_eq("class_id", int'(class_id), id);
         chk_eq("class_score", int'($signed(class_score)), mx);
         if (start_at_done) start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
         @(negedge clk);
         chk_eq("idle_after_done", int'(busy), 0);
         chk_eq("done_one_cycle", int'(done), 0);
         chk_eq("class_valid_held", int'(class_valid), 1);
         chk_eq("class_id_held", int'(class_id), id);
         chk_eq("raddr_idle", int'(sram_raddr_e0), BASE);
         chk_eq("done_count", done_cnt - d0, 1);
         chk_eq("raddr_count", alog_n, 3);
         for (int i = 0; i < 3 && i < alog_n; i++) chk_eq("raddr_seq", int'(alog[i]), BASE + i);
      end
   endtask

   task automatic check_reset_outputs();
      chk_eq("rst_score_valid", int'(score_valid), 0);
      chk_eq("rst_score_data", int'(score_data), 0);
      chk_eq("rst_score_idx", int'(score_idx), 0);
      chk_eq("rst_score_last", int'(score_last), 0);
      chk_eq("rst_class_valid", int'(class_valid), 0);
      chk_eq("rst_class_id", int'(class_id), 0);
      chk_eq("rst_class_score", int'(class_score), 0);
      chk_eq("rst_busy", int'(busy), 0);
      chk_eq("rst_done", int'(done), 0);
      chk_eq("rst_raddr", int'(sram_raddr_e0), BASE);
   endtask

   initial begin
      bit found;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      srstn = 1'b1;

      cur = '{3, -5, 7, 1, 0, 2, -128, 127, 9, 4};
      run_scores(0, 1'b0, 1'b0);

      for (int k = 0; k < 10; k++) cur[k] = -1;
      run_scores(0, 1'b0, 1'b1);

      cur = '{3, -5, 7, 1, 0, 2, -128, 127, 9, 4};
      run_scores(1, 1'b0, 1'b0);
      random_scores();
      run_scores(1, 1'b0, 1'b0);

      random_scores();
      run_scores(0, 1'b1, 1'b0);

      // Asynchronous reset while idx 5 is on the stream port.
      random_scores();
      load_scores();
      exp_pos  = 0;
      rdy_mode = 0;
      pulse_start();
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk);
         if (score_valid && score_idx == 4'd5) found = 1'b1;
      end
      chk_eq("reached_idx5", int'(found), 1);
      #2 srstn = 1'b0;
      #1;
      check_reset_outputs();
      repeat (2) @(posedge clk);
      #1 srstn = 1'b1;
      run_scores(0, 1'b0, 1'b0);

      for (int k = 0; k < 10; k++) cur[k] = k - 3;
      run_scores(0, 1'b0, 1'b0);

      for (int r = 0; r < 4; r++) begin
         random_scores();
         if (r == 1) cur[7] = cur[2];
         run_scores(int'($urandom_range(0, 1)), 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
